// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between the 16 requesters and the shared-mux arbiter.
// The arbiter side uses master; the requester side uses slave.
interface mux_select_arbiter_if;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;

    modport master (input req, output grant, output sel, output valid);
    modport slave  (output req, input grant, input sel, input valid);
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter for a shared 16:1 mux; drives one-hot grant, binary sel and valid.
// Latency: 1 cycle from req to registered grant/sel/valid; release hand-off needs no idle bubble.
// Backpressure: none; requesters hold req until granted. Optional ARB_HOLD_LIMIT_EN bounds ownership to HOLD_MAX cycles.
module mux_select_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_select_arbiter_if.master arb
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX must be in 2..255");
    end

    logic [0:0] state;
    logic [3:0] own;
    logic [3:0] ptr;
    logic [7:0] cnt;
    logic       hold_hit;
    logic [3:0] start;
    logic [3:0] win;

    always_comb begin
        hold_hit = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        hold_hit = (state == OWNED) && arb.req[own] && (cnt == 8'(HOLD_MAX - 1));
`endif
        // A forced rotation searches past the owner so it ends up last in line.
        start = hold_hit ? (own + 4'd1) : ptr;
        win   = start;
        for (int i = 15; i >= 0; i--) begin
            if (arb.req[start + 4'(i)]) begin
                win = start + 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            own       <= 4'd0;
            ptr       <= 4'd0;
            cnt       <= 8'd0;
            arb.grant <= 16'h0000;
            arb.sel   <= 4'd0;
            arb.valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|arb.req) begin
                        state     <= OWNED;
                        own       <= win;
                        ptr       <= win + 4'd1;
                        cnt       <= 8'd0;
                        arb.grant <= 16'h0001 << win;
                        arb.sel   <= win;
                        arb.valid <= 1'b1;
                    end
                end
                OWNED: begin
                    if (arb.req[own] && !hold_hit) begin
                        if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                    end else if (|arb.req) begin
                        own       <= win;
                        ptr       <= win + 4'd1;
                        cnt       <= 8'd0;
                        arb.grant <= 16'h0001 << win;
                        arb.sel   <= win;
                        arb.valid <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        arb.grant <= 16'h0000;
                        arb.sel   <= 4'd0;
                        arb.valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    arb.grant <= 16'h0000;
                    arb.sel   <= 4'd0;
                    arb.valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/mux_select_arbiter.md
# mux_select_arbiter

Round-robin arbiter sharing one 16:1 multiplexed resource, such as a shared register-read or bus port, among 16 requesters. It samples a 16-bit request vector and grants exactly one requester at a time. It drives the 4-bit `sel` that feeds the `mux16to1` select input, plus a one-hot `grant` and a `valid` flag. All outputs are registered, and grants are fair and starvation-free.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one owner keeps the grant while others wait. Legal range is 2..255. Used only when `ARB_HOLD_LIMIT_EN` is defined.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  reset, synchronous and active-low (0 = reset, sampled on `clk` rising edge).
- `req`  input  16  request vector; bit i = requester i wants the resource.
- `grant`  output  16  one-hot grant; all zero when idle.
- `sel`  output  4  binary index of the granted requester; drives `mux16to1` select.
- `valid`  output  1  1 when `grant` and `sel` are meaningful.

## Operation
- Internal state:
  - FSM states IDLE and OWNED.
  - Owner index `own[3:0]`.
  - Round-robin pointer `ptr[3:0]`.
  - Hold counter `cnt[7:0]`.
- Winner search: the first set bit of `req` scanning `ptr`, `ptr+1`, … `ptr+15`, modulo 16 (wraps 15 → 0).
- IDLE:
  - Outputs are `grant`=0, `sel`=0, `valid`=0.
  - If `req`≠0 at an edge, go to OWNED at that edge with `own`=winner, `ptr`=winner+1 mod 16, `cnt`=0.
- OWNED, `req[own]`=1, no hold limit reached: stay in OWNED; `grant`, `sel` unchanged; `cnt`++.
- OWNED, `req[own]`=0:
  - If other requests are pending, hand off directly to the next winner at that edge. There is no idle bubble. `ptr`=winner+1, `cnt`=0.
  - If no requests are pending, go to IDLE.
- Hold limit (macro enabled only):
  - Trigger: `req[own]`=1 and `cnt`=HOLD_MAX−1.
  - Re-arbitrate with the search starting at `own`+1, so the current owner has lowest priority.
  - If the owner is the sole requester, it is re-granted with `cnt`=0 and `valid` stays 1.
- Invariants:
  - `grant` = `valid` ? (1 << `sel`) : 0, at all times.
  - At most one `grant` bit is set.
- Pointer wrap: `ptr` after granting 15 is 0.
- `cnt` saturates at 255 when the hold limit is disabled. It has no functional effect in that case.

## Timing
- Reset values, applied at the first rising edge with `reset`=0:
  - Outputs: `grant`=16'h0000, `sel`=4'h0, `valid`=0.
  - Internal: FSM=IDLE, `ptr`=0, `own`=0, `cnt`=0.
- Reset mid-grant: outputs clear at the next edge regardless of `req`. The arbitration history is lost and `ptr` returns to 0.
- Grant latency: `req` is sampled at edge k, and `grant`/`sel`/`valid` update after edge k, giving 1 cycle from request to grant.
- Release latency: `req[own]` deasserted before edge k means the grant changes after edge k.
- Combinational paths: none from `req` to any output.
- Simultaneous release by the owner and assertion by a new requester at the same edge: the new requester is granted at that edge.
- A requester must hold `req` until it sees its grant. Dropping `req` earlier is legal; the request is simply not served.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined:
  - `cnt` compare logic is compiled in.
  - The owner is forcibly rotated after HOLD_MAX cycles whenever another request is pending.
- Not defined:
  - The owner keeps the grant for as long as `req[own]`=1. This is unbounded; fairness applies only at release.
  - The `HOLD_MAX` parameter is ignored.

## Test plan
- Reset with `req`=16'hFFFF held for 3 cycles: `grant`=0, `sel`=0, `valid`=0 throughout. The first edge after `reset`=1 gives `grant`=16'h0001, `sel`=0.
- `req`=16'h0020 alone: after 1 edge, `grant`=16'h0020, `sel`=5, `valid`=1. Drop `req`: after the next edge, `valid`=0, `grant`=0.
- `req`=16'h8001 from reset: `sel`=0 first. Clear bit 0: `sel`=15 on the same edge with no `valid` gap. Then set bit 0 and clear bit 15: `sel` wraps to 0.
- `HOLD_MAX`=4, macro on, `req`=16'h0003 held: `sel` sequence is 0,0,0,0,1,1,1,1,0,…. With the macro off, `sel` stays 0 indefinitely.
- `HOLD_MAX`=4, macro on, `req`=16'h0004 only, held for 10 cycles: `sel`=2 and `valid`=1 continuously, with no drop at the limit.
- Owner 7 granted, `reset` pulsed low for 1 cycle with `req`=16'h0180: outputs are 0 after the reset edge. The next edge grants `sel`=7, because `ptr` was reset to 0.
